gol_matrix_scan: RTL and testbench

- Display-side consumer of the Game-of-Life generation stream; it reads the 64-bit grid that the GOL core produces.
- Accepts each new grid over a valid/ready handshake into a pending buffer.
- Shows a stable snapshot on an 8x8 LED matrix, row by row, with inter-row blanking to avoid ghosting.
- The snapshot swaps only at frame boundaries, so a displayed frame never tears.

---
 rtl/gol_pkg.sv | 20 ++
 rtl/gol_grid_buffer.sv | 39 +++
 rtl/gol_matrix_scan.sv | 122 ++++++++++++
 tb/tb_gol_matrix_scan.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared grid geometry, scan FSM state type and row-extraction helper for the
// Game-of-Life LED matrix display path.
package gol_pkg;

    localparam int GRID_W   = 64;
    localparam int GRID_DIM = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    // Row r of the grid; row 0 occupies bits [7:0].
    function automatic logic [GRID_DIM-1:0] grid_row(input logic [GRID_W-1:0] grid,
                                                     input logic [2:0]        r);
        return grid[{r, 3'b000} +: GRID_DIM];
    endfunction

endpackage

// File: rtl/gol_grid_buffer.sv
// Double buffer between the GOL core and the scanner: one pending slot filled
// over valid/ready, and a displayed snapshot replaced only on a swap request.
module gol_grid_buffer
    import gol_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [GRID_W-1:0] grid_in,
    input  logic              grid_valid,
    input  logic              swap,
    output logic              grid_ready,
    output logic              pending_full,
    output logic              snap_valid,
    output logic [GRID_W-1:0] snapshot
);

    logic [GRID_W-1:0] pending;

    assign grid_ready = !pending_full;

    // The scanner only requests a swap while pending is full, so ready is low
    // then and a load can never collide with the swap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending      <= '0;
            pending_full <= 1'b0;
            snapshot     <= '0;
            snap_valid   <= 1'b0;
        end else if (swap) begin
            snapshot     <= pending;
            snap_valid   <= 1'b1;
            pending_full <= 1'b0;
        end else if (grid_valid && !pending_full) begin
            pending      <= grid_in;
            pending_full <= 1'b1;
        end
    end

endmodule

// File: rtl/gol_matrix_scan.sv
// 8x8 LED matrix scanner: blank, then drive each snapshot row in turn; the
// snapshot is swapped only at frame boundaries so a frame never tears.
module gol_matrix_scan
    import gol_pkg::*;
#(
    parameter int DWELL_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 4,
    parameter int COL_ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [GRID_W-1:0]   grid_in,
    input  logic                grid_valid,
    output logic                grid_ready,
    output logic [GRID_DIM-1:0] row_sel,
    output logic [GRID_DIM-1:0] col_drive,
    output logic                frame_start
);

    localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [GRID_DIM-1:0] POL = (COL_ACTIVE_LOW != 0) ? '1 : '0;

    scan_state_t       state, state_d;
    logic [2:0]        row, row_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic              swap, fs_d;
    logic              pending_full, snap_valid;
    logic [GRID_W-1:0] snapshot;

    gol_grid_buffer u_buf (
        .clk          (clk),
        .reset        (reset),
        .grid_in      (grid_in),
        .grid_valid   (grid_valid),
        .swap         (swap),
        .grid_ready   (grid_ready),
        .pending_full (pending_full),
        .snap_valid   (snap_valid),
        .snapshot     (snapshot)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            row         <= '0;
            cnt         <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_d;
            row         <= row_d;
            cnt         <= cnt_d;
            frame_start <= fs_d;
        end
    end

    always_comb begin
        state_d = state;
        row_d   = row;
        cnt_d   = cnt;
        swap    = 1'b0;
        fs_d    = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            row_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pending_full || snap_valid) begin
                        swap    = pending_full;
                        state_d = BLANK;
                        row_d   = '0;
                        cnt_d   = CW'(BLANK_CYCLES - 1);
                        fs_d    = 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt == '0) begin
                        state_d = DRIVE;
                        cnt_d   = CW'(DWELL_CYCLES - 1);
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state_d = BLANK;
                        cnt_d   = CW'(BLANK_CYCLES - 1);
                        if (row == 3'd7) begin
                            // Frame boundary: pick up a waiting generation, else redisplay.
                            swap  = pending_full;
                            row_d = '0;
                            fs_d  = 1'b1;
                        end else begin
                            row_d = row + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt - CW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decoded straight from the async-reset state so reset blanks the matrix at once.
    always_comb begin
        row_sel   = '0;
        col_drive = POL;
        if (state == DRIVE) begin
            row_sel   = GRID_DIM'(1) << row;
            col_drive = grid_row(snapshot, row) ^ POL;
        end
    end

endmodule

// File: tb/tb_gol_matrix_scan.sv
// Randomized self-checking bench for gol_matrix_scan against a frame-position
// reference model (cycle offset within the frame, pending/snapshot variables).
module tb_gol_matrix_scan;

    localparam int BLANK = 2;
    localparam int DWELL = 3;
    localparam int RP    = BLANK + DWELL;
    localparam int FRAME = 8 * RP;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [63:0] grid_in;
    logic        grid_valid;
    logic        grid_ready, grid_ready_al;
    logic [7:0]  row_sel, row_sel_al;
    logic [7:0]  col_drive, col_drive_al;
    logic        frame_start, frame_start_al;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state: m_t = cycle offset within the current frame, -1 when idle.
    int          m_t;
    bit          m_pf, m_sv, last_acc;
    logic [63:0] m_pend, m_snap;
    logic [63:0] offers[$];

    gol_matrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .COL_ACTIVE_LOW(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in),
        .grid_valid(grid_valid), .grid_ready(grid_ready), .row_sel(row_sel),
        .col_drive(col_drive), .frame_start(frame_start)
    );

    gol_matrix_scan #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANK), .COL_ACTIVE_LOW(1)) dut_al (
        .clk(clk), .reset(reset), .enable(enable), .grid_in(64'h0),
        .grid_valid(grid_valid), .grid_ready(grid_ready_al), .row_sel(row_sel_al),
        .col_drive(col_drive_al), .frame_start(frame_start_al)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_t = -1; m_pf = 0; m_sv = 0; m_pend = '0; m_snap = '0; last_acc = 0;
    endtask

    task automatic model_swap();
        m_snap = m_pend; m_sv = 1; m_pf = 0;
    endtask

    task automatic model_step();
        bit pf;
        pf       = m_pf;
        last_acc = grid_valid && !pf;
        if (!enable) m_t = -1;
        else if (m_t < 0) begin
            if (pf || m_sv) begin
                if (pf) model_swap();
                m_t = 0;
            end
        end else begin
            m_t++;
            if (m_t == FRAME) begin
                m_t = 0;
                if (pf) model_swap();
            end
        end
        if (last_acc) begin
            m_pend = grid_in;
            m_pf   = 1;
        end
    endtask

    task automatic check_all();
        logic [7:0] e_rs, e_col;
        int r, ph;
        e_rs = 8'h00; e_col = 8'h00;
        if (m_t >= 0) begin
            r  = m_t / RP;
            ph = m_t % RP;
            if (ph >= BLANK) begin
                e_rs  = 8'h01 << r;
                e_col = m_snap[r*8 +: 8];
            end
        end
        chk("row_sel", row_sel, e_rs);
        chk("col_drive", col_drive, e_col);
        chk("frame_start", frame_start, (m_t == 0));
        chk("grid_ready", grid_ready, !m_pf);
        chk("col_drive_al", col_drive_al, 8'hFF);
    endtask

    task automatic drive_offer();
        grid_valid = (offers.size() > 0);
        grid_in    = (offers.size() > 0) ? offers[0] : {$urandom, $urandom};
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        check_all();
        if (last_acc && offers.size() > 0) void'(offers.pop_front());
        drive_offer();
    endtask

    initial begin
        bit found;
        reset = 1'b0; enable = 1'b0; grid_valid = 1'b0; grid_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_row_sel", row_sel, 8'h00);
        chk("rst_col", col_drive, 8'h00);
        chk("rst_col_al", col_drive_al, 8'hFF);
        chk("rst_fs", frame_start, 1'b0);
        chk("rst_ready", grid_ready, 1'b1);

        // Directed frame-timing sequence, then a mid-frame burst of two grids.
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b1;
        offers.push_back(64'h8040201008040201);
        drive_offer();
        cyc = 0;
        repeat (130) begin
            if (cyc == 14) begin
                offers.push_back(64'h00000000000000FF);
                offers.push_back(64'h123456789ABCDEF0);
                drive_offer();
            end
            step();
            if (cyc == 2)  chk("fs_c2", frame_start, 1'b1);
            if (cyc == 4)  chk("rs_c4", {row_sel, col_drive}, 16'h0101);
            if (cyc == 6)  chk("rs_c6", {row_sel, col_drive}, 16'h0101);
            if (cyc == 9)  chk("rs_c9", {row_sel, col_drive}, 16'h0202);
            if (cyc == 20) chk("stall_c20", grid_ready, 1'b0);
            if (cyc == 42) chk("fs_c42", frame_start, 1'b1);
            if (cyc == 44) chk("row0_ff", {row_sel, col_drive}, 16'h01FF);
        end

        // Idle input for three frames: same snapshot redisplayed.
        repeat (3 * FRAME) step();

        // Drop enable in row 4 DRIVE, offer a grid while disabled, then resume.
        found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_t == 4 * RP + BLANK + 1) found = 1;
            else step();
        end
        chk("find_row4", found, 1'b1);
        enable = 1'b0;
        step();
        chk("dis_row_sel", row_sel, 8'h00);
        offers.push_back(64'hA5A5A5A55A5A5A5A);
        drive_offer();
        repeat (4) step();
        enable = 1'b1;
        repeat (2 * FRAME) step();

        // Random traffic with occasional enable drops.
        repeat (1500) begin
            if (offers.size() == 0 && $urandom_range(0, 7) == 0) begin
                offers.push_back({$urandom, $urandom});
                drive_offer();
            end
            if (enable && $urandom_range(0, 99) == 0) enable = 1'b0;
            else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
            step();
        end

        // Asynchronous reset in the middle of a DRIVE cycle.
        enable = 1'b1;
        found  = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_t >= 0 && (m_t % RP) >= BLANK) found = 1;
            else step();
        end
        chk("find_drive", found, 1'b1);
        chk("pre_rst_rs", (row_sel != 8'h00), 1'b1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("arst_row_sel", row_sel, 8'h00);
        chk("arst_col", col_drive, 8'h00);
        chk("arst_col_al", col_drive_al, 8'hFF);
        chk("arst_fs", frame_start, 1'b0);
        offers.delete();
        grid_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        chk("post_rst_ready", grid_ready, 1'b1);
        offers.push_back(64'h0F0F0F0F0F0F0F0F);
        drive_offer();
        repeat (FRAME + 10) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
